// File: rtl/button_irq_ctrl_pkg.sv
// Shared types for the button interrupt controller.
// FSM encoding and index-width helper.
package btn_irq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        HOLD = 2'd2
    } state_t;

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/button_irq_ctrl_if.sv
// Request/acknowledge link between the controller and the CPU.
// master = interrupt source, slave = CPU side.
interface button_irq_ctrl_if #(
    parameter int NUM_BTN = 4
);
    import btn_irq_pkg::*;

    localparam int IDX_W = idx_w(NUM_BTN);

    logic             int_req;
    logic             int_ack;
    logic [IDX_W-1:0] cause_id;
    logic             cause_release;

    modport master (
        output int_req,
        output cause_id,
        output cause_release,
        input  int_ack
    );

    modport slave (
        input  int_req,
        input  cause_id,
        input  cause_release,
        output int_ack
    );

endinterface

// File: rtl/button_irq_ctrl_edge_detect.sv
// Per-button edge detector with registered rise/fall pulses.
// prev loads the live level in reset so held buttons make no edge.
module btn_edge_detect (
    input  logic clk,
    input  logic clrn,
    input  logic btn,
    output logic rise,
    output logic fall
);

    logic prev;

    always_ff @(posedge clk) begin
        if (!clrn) begin
            prev <= btn;
            rise <= 1'b0;
            fall <= 1'b0;
        end else begin
            prev <= btn;
            rise <= btn & ~prev;
            fall <= ~btn & prev;
        end
    end

endmodule

// File: rtl/button_irq_ctrl.sv
// Button edges to a single CPU interrupt with hold-off.
// Optional release events: define BTN_IRQ_RELEASE_EN.
module button_irq_ctrl
    import btn_irq_pkg::*;
#(
    parameter int NUM_BTN        = 4,
    parameter int HOLDOFF_CYCLES = 100000,
    parameter int CNT_W          = 8
) (
    input  logic               clk,
    input  logic               clrn,
    input  logic [NUM_BTN-1:0] btn_db,
    input  logic [NUM_BTN-1:0] irq_mask,
    button_irq_ctrl_if.master  irq,
    output logic [NUM_BTN-1:0] pending,
    output logic [NUM_BTN-1:0] overrun,
    output logic [CNT_W-1:0]   ack_count
);

    localparam int IDX_W = idx_w(NUM_BTN);
    localparam int HLD_W =
        (HOLDOFF_CYCLES > 1) ? $clog2(HOLDOFF_CYCLES) : 1;

    state_t             state;
    logic               req;
    logic [IDX_W-1:0]   cause_q;
    logic               rel_q;
    logic [HLD_W-1:0]   hold;

    logic [NUM_BTN-1:0] rise;
    logic [NUM_BTN-1:0] fall;
    logic [NUM_BTN-1:0] set_p;
    logic [NUM_BTN-1:0] clr_p;
    logic [NUM_BTN-1:0] sel;
    logic [NUM_BTN-1:0] rel_pend;
    logic [NUM_BTN-1:0] ov_set;
    logic               ack_fire;
    logic               any;
    logic [IDX_W-1:0]   pick;
    logic               pick_rel;

    for (genvar i = 0; i < NUM_BTN; i++) begin : g_edge
        btn_edge_detect u_edge (
            .clk  (clk),
            .clrn (clrn),
            .btn  (btn_db[i]),
            .rise (rise[i]),
            .fall (fall[i])
        );
    end

    assign ack_fire = (state == REQ) & irq.int_ack;
    assign sel      = NUM_BTN'(1) << cause_q;
    assign set_p    = rise & irq_mask;
    assign clr_p    = (ack_fire & ~rel_q) ? sel : '0;

`ifdef BTN_IRQ_RELEASE_EN
    logic [NUM_BTN-1:0] set_r;
    logic [NUM_BTN-1:0] clr_r;

    assign set_r = fall & irq_mask;
    assign clr_r = (ack_fire & rel_q) ? sel : '0;

    always_ff @(posedge clk) begin
        if (!clrn) begin
            rel_pend <= '0;
        end else begin
            rel_pend <= (rel_pend & ~clr_r) | set_r;
        end
    end

    assign ov_set = (set_p & pending & ~clr_p)
                  | (set_r & rel_pend & ~clr_r);
`else
    logic unused_fall;

    assign unused_fall = ^fall;
    assign rel_pend    = '0;
    assign ov_set      = set_p & pending & ~clr_p;
`endif

    // Set beats clear, so an edge on the acked button re-pends it.
    always_ff @(posedge clk) begin
        if (!clrn) begin
            pending <= '0;
            overrun <= '0;
        end else begin
            pending <= (pending & ~clr_p) | set_p;
            overrun <= overrun | ov_set;
        end
    end

    // Lowest index wins; press beats release at the same index.
    always_comb begin
        any      = 1'b0;
        pick     = '0;
        pick_rel = 1'b0;
        for (int i = NUM_BTN - 1; i >= 0; i--) begin
            if (pending[i] | rel_pend[i]) begin
                any      = 1'b1;
                pick     = IDX_W'(i);
                pick_rel = ~pending[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!clrn) begin
            state     <= IDLE;
            req       <= 1'b0;
            cause_q   <= '0;
            rel_q     <= 1'b0;
            hold      <= '0;
            ack_count <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (any) begin
                        cause_q <= pick;
                        rel_q   <= pick_rel;
                        req     <= 1'b1;
                        state   <= REQ;
                    end
                end
                REQ: begin
                    if (irq.int_ack) begin
                        req       <= 1'b0;
                        ack_count <= ack_count + 1'b1;
                        hold      <= HLD_W'(HOLDOFF_CYCLES - 1);
                        state     <= HOLD;
                    end
                end
                HOLD: begin
                    if (hold == '0) begin
                        state <= IDLE;
                    end else begin
                        hold <= hold - 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign irq.int_req       = req;
    assign irq.cause_id      = cause_q;
    assign irq.cause_release = rel_q;

endmodule

// File: tb/tb_button_irq_ctrl.sv
// Scoreboard bench for button_irq_ctrl (NUM_BTN=4, HOLDOFF_CYCLES=4).
module tb_button_irq_ctrl;

    typedef struct packed {
        logic [1:0] id;
        logic       rel;
    } exp_t;

    logic       clk = 1'b0;
    logic       clrn;
    logic [3:0] btn_db;
    logic [3:0] irq_mask;
    logic [3:0] pending;
    logic [3:0] overrun;
    logic [7:0] ack_count;

    button_irq_ctrl_if #(.NUM_BTN(4)) bus ();

    button_irq_ctrl #(
        .NUM_BTN        (4),
        .HOLDOFF_CYCLES (4),
        .CNT_W          (8)
    ) dut (
        .clk       (clk),
        .clrn      (clrn),
        .btn_db    (btn_db),
        .irq_mask  (irq_mask),
        .irq       (bus.master),
        .pending   (pending),
        .overrun   (overrun),
        .ack_count (ack_count)
    );

    always #5 clk = ~clk;

    exp_t       sb[$];
    int         errors = 0;
    int         checks = 0;
    logic [7:0] exp_cnt = 8'd0;
    logic [3:0] btn = 4'd0;

    function automatic exp_t sb_pop();
        exp_t e;
        if (sb.size() == 0) begin
            e = 'x;
        end else begin
            e = sb.pop_front();
        end
        return e;
    endfunction

    task automatic press(input logic [3:0] bits);
        btn    = btn | bits;
        btn_db = btn;
    endtask

    task automatic release_masked(input logic [3:0] bits);
        logic [3:0] saved;
        saved    = irq_mask;
        irq_mask = 4'd0;
        btn      = btn & ~bits;
        btn_db   = btn;
        repeat (3) @(negedge clk);
        irq_mask = saved;
    endtask

    task automatic ack();
        bus.int_ack = 1'b1;
        @(negedge clk);
        bus.int_ack = 1'b0;
        exp_cnt = exp_cnt + 8'd1;
    endtask

    task automatic wait_req(output int cyc, output bit got);
        got = 1'b0;
        cyc = 0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (bus.int_req === 1'b1) begin
                cyc = k;
                got = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        clrn        = 1'b0;
        btn         = 4'b0001;
        btn_db      = btn;
        irq_mask    = 4'hF;
        bus.int_ack = 1'b0;
        repeat (3) @(negedge clk);
        clrn = 1'b1;
        repeat (6) @(negedge clk);
        checks++;
        if ({bus.int_req, pending, overrun} !== 9'd0) begin
            errors++;
            $display("FAIL reset_req_pend: req=%b pend=%b ovr=%b want 0",
                     bus.int_req, pending, overrun);
        end
        checks++;
        if ({ack_count, bus.cause_id, bus.cause_release} !== 11'd0) begin
            errors++;
            $display("FAIL reset_cnt_cause: cnt=%0d id=%0d rel=%b want 0",
                     ack_count, bus.cause_id, bus.cause_release);
        end
        release_masked(4'b0001);
    endtask

    task automatic test_single();
        int   cyc;
        bit   got;
        exp_t e;
        press(4'b0100);
        sb.push_back('{2'd2, 1'b0});
        wait_req(cyc, got);
        e = sb_pop();
        checks++;
        if ({got, bus.cause_id, bus.cause_release} !== {1'b1, e}) begin
            errors++;
            $display("FAIL single_cause: got=%b id=%0d rel=%b want id=%0d rel=%b",
                     got, bus.cause_id, bus.cause_release, e.id, e.rel);
        end
        checks++;
        if (cyc !== 3) begin
            errors++;
            $display("FAIL single_latency: %0d cycles want 3", cyc);
        end
        checks++;
        if (pending !== 4'b0100) begin
            errors++;
            $display("FAIL single_pending: %b want 0100", pending);
        end
        repeat (3) @(negedge clk);
        checks++;
        if ({bus.int_req, bus.cause_id} !== {1'b1, 2'd2}) begin
            errors++;
            $display("FAIL single_hold_req: req=%b id=%0d want 1/2",
                     bus.int_req, bus.cause_id);
        end
        ack();
        checks++;
        if ({bus.int_req, pending, ack_count} !== {1'b0, 4'd0, exp_cnt}) begin
            errors++;
            $display("FAIL single_ack: req=%b pend=%b cnt=%0d want 0/0000/%0d",
                     bus.int_req, pending, ack_count, exp_cnt);
        end
        release_masked(4'b0100);
    endtask

    task automatic test_simultaneous();
        int   cyc;
        bit   got;
        exp_t e;
        press(4'b1010);
        sb.push_back('{2'd1, 1'b0});
        sb.push_back('{2'd3, 1'b0});
        wait_req(cyc, got);
        e = sb_pop();
        checks++;
        if ({got, bus.cause_id, bus.cause_release} !== {1'b1, e}) begin
            errors++;
            $display("FAIL simul_first: got=%b id=%0d want %0d",
                     got, bus.cause_id, e.id);
        end
        ack();
        checks++;
        if (pending !== 4'b1000) begin
            errors++;
            $display("FAIL simul_pending: %b want 1000", pending);
        end
        got = 1'b0;
        cyc = 0;
        for (int k = 1; k <= 20; k++) begin
            bus.int_ack = (k == 2);
            @(negedge clk);
            if (bus.int_req === 1'b1) begin
                cyc = k;
                got = 1'b1;
                break;
            end
        end
        bus.int_ack = 1'b0;
        checks++;
        if (cyc !== 5) begin
            errors++;
            $display("FAIL simul_holdoff: req after %0d cycles want 5", cyc);
        end
        checks++;
        if (ack_count !== exp_cnt) begin
            errors++;
            $display("FAIL simul_hold_ack_ignored: cnt=%0d want %0d",
                     ack_count, exp_cnt);
        end
        e = sb_pop();
        checks++;
        if ({got, bus.cause_id, bus.cause_release} !== {1'b1, e}) begin
            errors++;
            $display("FAIL simul_second: got=%b id=%0d want %0d",
                     got, bus.cause_id, e.id);
        end
        ack();
        checks++;
        if (ack_count !== exp_cnt) begin
            errors++;
            $display("FAIL simul_count: %0d want %0d", ack_count, exp_cnt);
        end
        release_masked(4'b1010);
    endtask

    task automatic test_overrun();
        int   cyc;
        bit   got;
        exp_t e;
        press(4'b0001);
        sb.push_back('{2'd0, 1'b0});
        wait_req(cyc, got);
        e = sb_pop();
        checks++;
        if ({got, bus.cause_id, bus.cause_release} !== {1'b1, e}) begin
            errors++;
            $display("FAIL ovr_cause: got=%b id=%0d want %0d",
                     got, bus.cause_id, e.id);
        end
        release_masked(4'b0001);
        press(4'b0001);
        repeat (2) @(negedge clk);
        checks++;
        if ({overrun, pending} !== {4'b0001, 4'b0001}) begin
            errors++;
            $display("FAIL ovr_set: ovr=%b pend=%b want 0001/0001",
                     overrun, pending);
        end
        ack();
        checks++;
        if ({bus.int_req, pending} !== 5'd0) begin
            errors++;
            $display("FAIL ovr_ack_clear: req=%b pend=%b want 0/0000",
                     bus.int_req, pending);
        end
        repeat (8) @(negedge clk);
        ack();
        exp_cnt = exp_cnt - 8'd1;
        repeat (2) @(negedge clk);
        checks++;
        if ({bus.int_req, ack_count} !== {1'b0, exp_cnt}) begin
            errors++;
            $display("FAIL ovr_idle_ack: req=%b cnt=%0d want 0/%0d",
                     bus.int_req, ack_count, exp_cnt);
        end
        release_masked(4'b0001);
    endtask

    task automatic test_ack_collision();
        int   cyc;
        bit   got;
        exp_t e;
        press(4'b0100);
        sb.push_back('{2'd2, 1'b0});
        wait_req(cyc, got);
        e = sb_pop();
        checks++;
        if ({got, bus.cause_id, bus.cause_release} !== {1'b1, e}) begin
            errors++;
            $display("FAIL coll_cause: got=%b id=%0d want %0d",
                     got, bus.cause_id, e.id);
        end
        release_masked(4'b0100);
        press(4'b0100);
        @(negedge clk);
        ack();
        checks++;
        if ({bus.int_req, pending, overrun} !== {1'b0, 4'b0100, 4'b0001}) begin
            errors++;
            $display("FAIL coll_set_wins: req=%b pend=%b ovr=%b want 0/0100/0001",
                     bus.int_req, pending, overrun);
        end
        sb.push_back('{2'd2, 1'b0});
        irq_mask = 4'd0;
        press(4'b0010);
        wait_req(cyc, got);
        e = sb_pop();
        checks++;
        if ({got, bus.cause_id, bus.cause_release} !== {1'b1, e}) begin
            errors++;
            $display("FAIL coll_masked_serviced: got=%b id=%0d want %0d",
                     got, bus.cause_id, e.id);
        end
        checks++;
        if ({cyc, pending} !== {32'd5, 4'b0100}) begin
            errors++;
            $display("FAIL coll_holdoff_mask: cyc=%0d pend=%b want 5/0100",
                     cyc, pending);
        end
        ack();
        irq_mask = 4'hF;
        release_masked(4'b0110);
    endtask

    task automatic test_wrap();
        int   cyc;
        bit   got;
        int   n;
        int   bad;
        exp_t e;
        n   = 256 - int'(exp_cnt);
        bad = 0;
        for (int i = 0; i < n; i++) begin
            press(4'b0001);
            sb.push_back('{2'd0, 1'b0});
            wait_req(cyc, got);
            e = sb_pop();
            if ({got, bus.cause_id, bus.cause_release} !== {1'b1, e}) begin
                bad++;
            end
            ack();
            release_masked(4'b0001);
        end
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL wrap_requests: %0d bad requests want 0", bad);
        end
        checks++;
        if (ack_count !== 8'd0) begin
            errors++;
            $display("FAIL wrap_count: %0d want 0", ack_count);
        end
    endtask

    task automatic test_reset_mid_req();
        int   cyc;
        bit   got;
        exp_t e;
        press(4'b0010);
        sb.push_back('{2'd1, 1'b0});
        wait_req(cyc, got);
        e = sb_pop();
        checks++;
        if ({got, bus.cause_id, bus.cause_release} !== {1'b1, e}) begin
            errors++;
            $display("FAIL rstreq_cause: got=%b id=%0d want %0d",
                     got, bus.cause_id, e.id);
        end
        clrn = 1'b0;
        @(negedge clk);
        checks++;
        if ({bus.int_req, pending, overrun, ack_count} !== 17'd0) begin
            errors++;
            $display("FAIL rstreq_drop: req=%b pend=%b ovr=%b cnt=%0d want 0",
                     bus.int_req, pending, overrun, ack_count);
        end
        clrn    = 1'b1;
        exp_cnt = 8'd0;
        repeat (8) @(negedge clk);
        checks++;
        if ({bus.int_req, pending} !== 5'd0) begin
            errors++;
            $display("FAIL rstreq_held_btn: req=%b pend=%b want 0",
                     bus.int_req, pending);
        end
        release_masked(4'b0010);
    endtask

    task automatic test_release();
        int   cyc;
        bit   got;
        exp_t e;
        press(4'b0100);
        sb.push_back('{2'd2, 1'b0});
        wait_req(cyc, got);
        e = sb_pop();
        checks++;
        if ({got, bus.cause_id, bus.cause_release} !== {1'b1, e}) begin
            errors++;
            $display("FAIL rel_press: got=%b id=%0d rel=%b want %0d/%b",
                     got, bus.cause_id, bus.cause_release, e.id, e.rel);
        end
        ack();
        btn    = btn & ~4'b0100;
        btn_db = btn;
`ifdef BTN_IRQ_RELEASE_EN
        sb.push_back('{2'd2, 1'b1});
        wait_req(cyc, got);
        e = sb_pop();
        checks++;
        if ({got, bus.cause_id, bus.cause_release} !== {1'b1, e}) begin
            errors++;
            $display("FAIL rel_release: got=%b id=%0d rel=%b want %0d/%b",
                     got, bus.cause_id, bus.cause_release, e.id, e.rel);
        end
        ack();
`else
        repeat (15) @(negedge clk);
        checks++;
        if ({bus.int_req, pending} !== 5'd0) begin
            errors++;
            $display("FAIL rel_ignored: req=%b pend=%b want 0",
                     bus.int_req, pending);
        end
`endif
        checks++;
        if ({ack_count, sb.size() == 0} !== {exp_cnt, 1'b1}) begin
            errors++;
            $display("FAIL rel_count: cnt=%0d left=%0d want %0d/0",
                     ack_count, sb.size(), exp_cnt);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single();
        test_simultaneous();
        test_overrun();
        test_ack_collision();
        test_wrap();
        test_reset_mid_req();
        test_release();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
